// File: rtl/mem_seq_pkg.sv
// Shared encodings for the byte-serial memory sequencer.
package mem_seq_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index of the final byte of a transfer of the given size.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SZ_HALF: last_idx = 2'd1;
      SZ_WORD: last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  endfunction

  // Illegal size or natural-alignment violation; rejected without touching the RAM.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Zero/sign extension of an assembled little-endian load result.
module load_ext
  import mem_seq_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Extend from bit 7 or bit 15; words pass through untouched.
  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      SZ_HALF: ext = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/byte_mem_sequencer.sv
// Splits byte/half/word loads and stores into single-byte accesses on an
// 8-bit RAM, one byte per cycle, little-endian.
module byte_mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [BYTE_WIDTH-1:0] inD,
  output logic                  str,
  input  logic [BYTE_WIDTH-1:0] outD
);

  state_t                state;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           raw_q;
  logic [31:0]           raw_next;
  logic [31:0]           ext_data;
  logic [1:0]            k_q;
  logic [1:0]            k_nx;

  assign req_ready = (state == IDLE);
  assign k_nx      = k_q + 2'd1;

  // Result so far with the byte currently on outD merged in at lane k.
  always_comb begin
    raw_next = raw_q;
    raw_next[{k_q, 3'b000} +: BYTE_WIDTH] = outD;
  end

  load_ext u_load_ext (
    .size        (size_q),
    .is_unsigned (uns_q),
    .raw         (raw_next),
    .ext         (ext_data)
  );

  // Sequencer FSM; RAM-side and response outputs are all registered so they
  // are already valid at the start of the cycle they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      raw_q      <= '0;
      k_q        <= '0;
      A          <= '0;
      inD        <= '0;
      str        <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            base_q  <= req_addr;
            wdata_q <= req_wdata;
            raw_q   <= '0;
            k_q     <= '0;
            if (misaligned(req_size, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state <= XFER;
              A     <= req_addr;
              str   <= req_we;
              inD   <= req_we ? req_wdata[BYTE_WIDTH-1:0] : '0;
            end
          end
        end
        XFER: begin
          raw_q <= raw_next;
          if (k_q == last_idx(size_q)) begin
            state      <= RESP;
            A          <= '0;
            inD        <= '0;
            str        <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= we_q ? 32'd0 : ext_data;
          end else begin
            k_q <= k_nx;
            A   <= base_q + ADDR_WIDTH'(k_nx);
            inD <= we_q ? wdata_q[{k_nx, 3'b000} +: BYTE_WIDTH] : '0;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          k_q        <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_mem_sequencer.sv
// Directed + random bench for byte_mem_sequencer with a byte-array RAM and
// a transaction-level reference memory.
module tb_byte_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  A;
  logic [7:0]  inD;
  logic        str;
  logic [7:0]  outD;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] ram    [0:1023] = '{default: 8'h00};
  logic [7:0] refmem [0:1023] = '{default: 8'h00};

  byte_mem_sequencer #(.ADDR_WIDTH(10), .BYTE_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .A            (A),
    .inD          (inD),
    .str          (str),
    .outD         (outD)
  );

  always #5 clk = ~clk;

  // Attached RAM: write on strobe, combinational read.
  always @(posedge clk) if (str) ram[A] <= inD;
  assign outD = ram[A];

  `define CHK(tag, obs, exp) \
    n_assert++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end

  // One request, checked against the reference memory. Entered and left at a
  // negedge in IDLE.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wd, input string tag);
    int n, lat, strc;
    logic err, side_bad, range_bad, got_err;
    logic [31:0] got_rd, exp;
    longint v;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((int'(addr) % n) != 0);
    exp = 32'd0;
    if (!err && we) begin
      for (int i = 0; i < n; i++) refmem[int'(addr) + i] = wd[8*i +: 8];
    end else if (!err) begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(refmem[int'(addr) + i]) * (longint'(1) << (8*i));
      if (n < 4 && !uns && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
      exp = 32'(v);
    end
    `CHK({tag, "_ready"}, req_ready, 1'b1)
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = 10'($urandom); req_wdata = $urandom;
    lat = 0; strc = 0; side_bad = 1'b0; range_bad = 1'b0; got_rd = 'x; got_err = 1'bx;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (str) begin
        strc++;
        if (int'(A) < int'(addr) || int'(A) >= int'(addr) + n) range_bad = 1'b1;
      end
      if (resp_valid) begin
        lat = cyc; got_rd = resp_rdata; got_err = resp_err;
        if (str !== 1'b0 || A !== 10'd0 || inD !== 8'd0) side_bad = 1'b1;
        break;
      end else if (resp_rdata !== 32'd0 || resp_err !== 1'b0) side_bad = 1'b1;
    end
    `CHK({tag, "_latency"}, lat, (err ? 1 : n + 1))
    `CHK({tag, "_err"}, got_err, err)
    `CHK({tag, "_rdata"}, got_rd, exp)
    `CHK({tag, "_strobes"}, strc, ((we && !err) ? n : 0))
    `CHK({tag, "_quiet"}, {side_bad, range_bad}, 2'b00)
    @(negedge clk);
  endtask

  int mism, acc, last_acc;
  logic bad;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    `CHK("rst_ctl", {req_ready, str, resp_valid, resp_err}, 4'b1000)
    `CHK("rst_data", {resp_rdata, A, inD}, 50'd0)
    rst = 1'b0;
    @(negedge clk);
    `CHK("post_rst_ready", req_ready, 1'b1)

    // Directed word store / loads
    do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, "st_word");
    `CHK("st_word_ram", {ram[19], ram[18], ram[17], ram[16]}, 32'hDEADBEEF)
    do_req(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, "ld_word");
    do_req(1'b0, 2'd0, 1'b0, 10'h013, 32'h0, "ld_byte_s");
    do_req(1'b0, 2'd0, 1'b1, 10'h013, 32'h0, "ld_byte_u");
    do_req(1'b0, 2'd1, 1'b0, 10'h012, 32'h0, "ld_half_s");
    do_req(1'b0, 2'd1, 1'b1, 10'h012, 32'h0, "ld_half_u");
    do_req(1'b0, 2'd2, 1'b0, 10'h011, 32'h0, "ld_misal");
    do_req(1'b1, 2'd3, 1'b0, 10'h010, 32'h12345678, "st_illegal");
    do_req(1'b1, 2'd1, 1'b0, 10'h015, 32'h0000CAFE, "st_half_misal");
    do_req(1'b1, 2'd2, 1'b0, 10'h3FC, 32'hA1B2C3D4, "st_word_top");
    do_req(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0, "ld_word_top");

    // Reset during the second XFER cycle of a word store
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 10'h020; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    `CHK("midrst_outputs", {str, resp_valid, A, inD}, 20'd0)
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    refmem[32] = 8'h44;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad = 1'b1;
    end
    `CHK("midrst_no_resp", bad, 1'b0)
    `CHK("midrst_ram", {ram[35], ram[34], ram[33], ram[32]}, 32'h00000044)
    do_req(1'b0, 2'd2, 1'b0, 10'h020, 32'h0, "post_midrst_ld");

    // Back-to-back byte stores with req_valid held high
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
    req_addr = 10'h200; req_wdata = 32'h0000005A;
    acc = 0; last_acc = -1; bad = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (req_ready) begin
        if (last_acc >= 0 && cyc - last_acc != 3) bad = 1'b1;
        last_acc = cyc; acc++;
        refmem[int'(req_addr)] = req_wdata[7:0];
      end else begin
        req_addr = 10'h200 + 10'($urandom_range(0, 255));
        req_wdata = $urandom;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    `CHK("b2b_accepts", acc, 5)
    `CHK("b2b_spacing", bad, 1'b0)
    repeat (3) @(negedge clk);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom),
             10'h100 + 10'($urandom_range(0, 250)), $urandom, "rand");
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== refmem[i]) mism++;
    `CHK("ram_image", mism, 0)

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
